// File: rtl/serial_rx_scheduler.sv
// serial_rx_scheduler: one shared serial-to-parallel word assembler,
// time-shared between N_CH serial sources by a round-robin arbiter.
module serial_rx_scheduler #(
   parameter  int unsigned N_CH   = 4,
   parameter  int unsigned WORD_W = 8,
   localparam int unsigned CH_W   = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_CH-1:0]   req,
   input  logic [N_CH-1:0]   bit_in,
   input  logic              flush,
   output logic [N_CH-1:0]   grant,
   output logic              busy,
   output logic [WORD_W-1:0] word,
   output logic [CH_W-1:0]   word_ch,
   output logic              word_valid,
   input  logic              word_ready
);

   localparam int unsigned CNT_W = $clog2(WORD_W);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t              state_q;
   logic [CH_W-1:0]     ptr_q;
   logic [CH_W-1:0]     ch_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [WORD_W-1:0]   shreg_q;
   logic [WORD_W-1:0]   word_q;
   logic [CH_W-1:0]     word_ch_q;
   logic                word_valid_q;
   logic [N_CH-1:0]     grant_q;
   logic                busy_q;

   logic                pick_vld;
   logic [CH_W-1:0]     pick_ch;
   logic [N_CH-1:0]     grant_d;
   logic [WORD_W-1:0]   shreg_d;
   logic [CH_W-1:0]     ptr_d;
   logic                last_bit;

   // Round-robin pick: first requester at or after ptr_q, wrapping modulo N_CH.
   always_comb begin
      int idx;
      pick_vld = 1'b0;
      pick_ch  = '0;
      idx      = 0;
      for (int k = int'(N_CH) - 1; k >= 0; k--) begin
         idx = (int'(ptr_q) + k) % int'(N_CH);
         if (req[CH_W'(idx)]) begin
            pick_vld = 1'b1;
            pick_ch  = CH_W'(idx);
         end
      end
   end

   // Shift datapath and pointer helpers for the currently granted channel.
   always_comb begin
      grant_d  = N_CH'(1) << pick_ch;
      shreg_d  = {shreg_q[WORD_W-2:0], bit_in[ch_q]};
      ptr_d    = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + CH_W'(1);
      last_bit = (cnt_q == CNT_W'(WORD_W - 1));
   end

   // Scheduler FSM with registered grant/busy and output word holding.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         ch_q         <= '0;
         cnt_q        <= '0;
         shreg_q      <= '0;
         word_q       <= '0;
         word_ch_q    <= '0;
         word_valid_q <= 1'b0;
         grant_q      <= '0;
         busy_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_vld) begin
                  ch_q    <= pick_ch;
                  cnt_q   <= '0;
                  grant_q <= grant_d;
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               if (flush) begin
                  // Abort wins even on the final bit edge.
                  cnt_q   <= '0;
                  shreg_q <= '0;
                  ptr_q   <= ptr_d;
                  grant_q <= '0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  shreg_q <= shreg_d;
                  cnt_q   <= cnt_q + CNT_W'(1);
                  if (last_bit) begin
                     cnt_q        <= '0;
                     word_q       <= shreg_d;
                     word_ch_q    <= ch_q;
                     word_valid_q <= 1'b1;
                     ptr_q        <= ptr_d;
                     grant_q      <= '0;
                     state_q      <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (word_ready) begin
                  word_valid_q <= 1'b0;
                  busy_q       <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: begin
               grant_q <= '0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign grant      = grant_q;
   assign busy       = busy_q;
   assign word       = word_q;
   assign word_ch    = word_ch_q;
   assign word_valid = word_valid_q;

endmodule

// File: tb/tb_serial_rx_scheduler.sv
// Bench for serial_rx_scheduler: directed scenarios plus random traffic,
// checked every cycle against a transaction-level reference model.
module tb_serial_rx_scheduler;

   localparam int unsigned N_CH   = 4;
   localparam int unsigned WORD_W = 8;
   localparam int unsigned CH_W   = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N_CH-1:0]   req;
   logic [N_CH-1:0]   bit_in;
   logic              flush;
   logic [N_CH-1:0]   grant;
   logic              busy;
   logic [WORD_W-1:0] word;
   logic [CH_W-1:0]   word_ch;
   logic              word_valid;
   logic              word_ready;

   always #5 clk = ~clk;

   serial_rx_scheduler #(.N_CH(N_CH), .WORD_W(WORD_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .bit_in     (bit_in),
      .flush      (flush),
      .grant      (grant),
      .busy       (busy),
      .word       (word),
      .word_ch    (word_ch),
      .word_valid (word_valid),
      .word_ready (word_ready)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: active channel (-1 none), bits still to receive,
   // accumulated value, and a pending completed word awaiting acceptance.
   int          m_act;
   int          m_left;
   int          m_ptr;
   int unsigned m_acc;
   bit          m_hold;
   int unsigned m_word;
   int          m_wch;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance the model by one clock using the inputs as currently driven.
   task automatic model_step();
      if (!rst_n) begin
         m_act = -1; m_left = 0; m_ptr = 0; m_acc = 0;
         m_hold = 1'b0; m_word = 0; m_wch = 0;
      end else if (m_hold) begin
         if (word_ready) m_hold = 1'b0;
      end else if (m_act >= 0) begin
         if (flush) begin
            m_ptr = (m_act + 1) % N_CH;
            m_act = -1;
            m_acc = 0;
         end else begin
            m_acc  = m_acc * 2 + int'(bit_in[m_act]);
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_word = m_acc % (1 << WORD_W);
               m_wch  = m_act;
               m_hold = 1'b1;
               m_ptr  = (m_act + 1) % N_CH;
               m_act  = -1;
               m_acc  = 0;
            end
         end
      end else begin
         for (int k = 0; k < N_CH; k++) begin
            int c;
            c = (m_ptr + k) % N_CH;
            if (m_act < 0 && req[c]) begin
               m_act  = c;
               m_left = WORD_W;
               m_acc  = 0;
            end
         end
      end
   endtask

   // One clock: update model, let the edge pass, compare all outputs.
   task automatic step();
      int exp_grant;
      model_step();
      @(posedge clk);
      #1;
      exp_grant = (m_act >= 0) ? (1 << m_act) : 0;
      check("grant",      32'(grant),      32'(exp_grant));
      check("busy",       32'(busy),       32'((m_act >= 0) || m_hold));
      check("word_valid", 32'(word_valid), 32'(m_hold));
      check("word",       32'(word),       32'(m_word));
      check("word_ch",    32'(word_ch),    32'(m_wch));
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req = '0; bit_in = '0; flush = 1'b0; word_ready = 1'b1;
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0]       pat;
      logic [CH_W-1:0]  rr_q[$];
      int               exp_order [5];

      // 1: single word 0xAA on ch2
      do_reset();
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_valid", 32'(word_valid), 32'h0);
      pat = 8'hAA;
      req = 4'b0100;
      step();
      req = '0;
      for (int k = 0; k < 8; k++) begin
         check("t1_grant_on", 32'(grant), 32'h4);
         bit_in = 4'($urandom) & 4'b1011;
         bit_in[2] = pat[7 - k];
         step();
      end
      check("t1_grant_off", 32'(grant), 32'h0);
      check("t1_valid", 32'(word_valid), 32'h1);
      check("t1_word", 32'(word), 32'hAA);
      check("t1_word_ch", 32'(word_ch), 32'h2);
      step();
      check("t1_valid_1cyc", 32'(word_valid), 32'h0);

      // 2: round robin with all channels requesting
      do_reset();
      req = 4'b1111;
      for (int c = 0; c < 55; c++) begin
         bit_in = 4'($urandom);
         step();
         if (word_valid && word_ready) rr_q.push_back(word_ch);
      end
      exp_order = '{0, 1, 2, 3, 0};
      check("t2_count", 32'(rr_q.size() >= 5), 32'h1);
      for (int i = 0; i < 5; i++)
         check("t2_order", (i < rr_q.size()) ? 32'(rr_q[i]) : 32'hFF, 32'(exp_order[i]));

      // 3: backpressure on ch0
      do_reset();
      req = 4'b0001; word_ready = 1'b0;
      for (int c = 0; c < 9; c++) begin bit_in = 4'($urandom); step(); end
      for (int c = 0; c < 5; c++) begin
         check("t3_hold_valid", 32'(word_valid), 32'h1);
         check("t3_hold_busy", 32'(busy), 32'h1);
         bit_in = 4'($urandom); step();
      end
      word_ready = 1'b1;
      step();
      check("t3_released", 32'(word_valid), 32'h0);
      step();
      check("t3_regrant", 32'(grant), 32'h1);

      // 4: flush on 4th granted cycle of ch1, next grant goes to ch2
      do_reset();
      req = 4'b0010;
      step();
      for (int c = 0; c < 3; c++) begin bit_in = 4'($urandom); step(); end
      flush = 1'b1; step(); flush = 1'b0;
      check("t4_grant_drop", 32'(grant), 32'h0);
      req = 4'b0110;
      step();
      check("t4_next_ch2", 32'(grant), 32'h4);
      for (int c = 0; c < 9; c++) begin bit_in = 4'($urandom); step(); end

      // 5: flush on final bit edge, then flush during HOLD
      do_reset();
      req = 4'b0001;
      step();
      for (int c = 0; c < 7; c++) begin bit_in = 4'($urandom); step(); end
      flush = 1'b1; step(); flush = 1'b0;
      check("t5_no_word", 32'(word_valid), 32'h0);
      word_ready = 1'b0;
      for (int c = 0; c < 9; c++) begin bit_in = 4'($urandom); step(); end
      flush = 1'b1;
      for (int c = 0; c < 3; c++) step();
      check("t5_kept", 32'(word_valid), 32'h1);
      flush = 1'b0; word_ready = 1'b1;
      step();

      // 6: reset mid-SHIFT and mid-HOLD, arbitration restarts at ch0
      do_reset();
      req = 4'b1000;
      for (int c = 0; c < 4; c++) begin bit_in = 4'($urandom); step(); end
      rst_n = 1'b0; step(); rst_n = 1'b1;
      check("t6_shift_rst", 32'(busy), 32'h0);
      req = 4'b1111;
      step();
      check("t6_ch0_first", 32'(grant), 32'h1);
      word_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin bit_in = 4'($urandom); step(); end
      rst_n = 1'b0; step(); rst_n = 1'b1;
      check("t6_hold_rst", 32'(word_valid), 32'h0);
      word_ready = 1'b1;
      step();
      check("t6_ch0_again", 32'(grant), 32'h1);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         rst_n      = ($urandom_range(0, 199) != 0);
         req        = 4'($urandom);
         bit_in     = 4'($urandom);
         flush      = ($urandom_range(0, 19) == 0);
         word_ready = ($urandom_range(0, 9) < 7);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
